// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state and transaction owner.
// Ports: none (package only). Imported by mem_port_arbiter and arb_starve_ctr.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    OWN_IF = 2'd1,
    OWN_LS = 2'd2
  } arb_owner_t;

  // Width of the optional performance counters.
  localparam int unsigned PERF_CNT_W = 32;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of arbitrations the IF requester has lost in a row.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   inc_i     - IF lost an arbitration this cycle
//   clr_i     - IF was granted this cycle (takes precedence over inc_i)
//   sat_o     - registered flag, count has reached MAX_WAIT
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q;

  // Next count: clear wins, increment stops at MAX_WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_W'(MAX_WAIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Saturation flag is computed from the next count so it tracks cnt_q exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= (cnt_d == CNT_W'(MAX_WAIT));
    end
  end

  assign sat_o = sat_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// One outstanding transaction; LS has priority unless IF has lost MAX_WAIT
// arbitrations in a row. Responses are routed back to the owning requester.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   if_req_* / if_rsp_*          - IF read request / response
//   ls_req_*, ls_* / ls_rsp_*    - LS read/write request / response
//   mem_req_*, mem_* / mem_rsp_* - memory request (latched fields) / response
//   busy                         - transaction in flight
//   protocol_err                 - sticky, unexpected memory response seen
// Optional: define ARB_PERF_CNT_EN to add if_grant_cnt, ls_grant_cnt and
// stall_cnt (cycles in ISSUE waiting for mem_req_ready).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]         if_grant_cnt,
  output logic [31:0]         ls_grant_cnt,
  output logic [31:0]         stall_cnt,
`endif
  output logic                busy,
  output logic                protocol_err
);

  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_t        state_q;
  arb_owner_t        owner_q;
  logic              mem_req_valid_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [STRB_W-1:0] mem_wstrb_q;
  logic              busy_q;
  logic              protocol_err_q;
  logic              if_rsp_valid_q;
  logic [DATA_W-1:0] if_rsp_data_q;
  logic              ls_rsp_valid_q;
  logic [DATA_W-1:0] ls_rsp_data_q;

  logic grant_if;
  logic grant_ls;
  logic starve_sat;
  logic deliver;
  logic rsp_err;

  // Arbitration in IDLE: a starved IF beats LS, otherwise LS beats IF.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state_q == IDLE) begin
      if (if_req_valid && starve_sat) begin
        grant_if = 1'b1;
      end else if (ls_req_valid) begin
        grant_ls = 1'b1;
      end else if (if_req_valid) begin
        grant_if = 1'b1;
      end
    end
  end

  // A response is accepted only once the request has been taken by memory.
  assign deliver = mem_rsp_valid &&
                   (((state_q == ISSUE) && mem_req_ready) || (state_q == WAIT_RSP));
  assign rsp_err = mem_rsp_valid &&
                   ((state_q == IDLE) || ((state_q == ISSUE) && !mem_req_ready));

  arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc_i (grant_ls && if_req_valid),
    .clr_i (grant_if),
    .sat_o (starve_sat)
  );

  // Transaction FSM with registered request fields and response delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      owner_q         <= NONE;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wstrb_q     <= '0;
      busy_q          <= 1'b0;
      protocol_err_q  <= 1'b0;
      if_rsp_valid_q  <= 1'b0;
      if_rsp_data_q   <= '0;
      ls_rsp_valid_q  <= 1'b0;
      ls_rsp_data_q   <= '0;
    end else begin
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;

      if (rsp_err) begin
        protocol_err_q <= 1'b1;
      end

      if (deliver) begin
        if (owner_q == OWN_IF) begin
          if_rsp_valid_q <= 1'b1;
          if_rsp_data_q  <= mem_rsp_data;
        end else if (owner_q == OWN_LS) begin
          ls_rsp_valid_q <= 1'b1;
          // Writes are acknowledged with zero data.
          ls_rsp_data_q  <= mem_we_q ? '0 : mem_rsp_data;
        end
      end

      case (state_q)
        IDLE: begin
          if (grant_ls) begin
            mem_we_q    <= ls_we;
            mem_addr_q  <= ls_addr;
            mem_wdata_q <= ls_wdata;
            mem_wstrb_q <= ls_wstrb;
            owner_q     <= OWN_LS;
          end else if (grant_if) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            owner_q     <= OWN_IF;
          end
          if (grant_ls || grant_if) begin
            state_q         <= ISSUE;
            mem_req_valid_q <= 1'b1;
            busy_q          <= 1'b1;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            if (mem_rsp_valid) begin
              state_q <= IDLE;
              owner_q <= NONE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            state_q <= IDLE;
            owner_q <= NONE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q         <= IDLE;
          owner_q         <= NONE;
          mem_req_valid_q <= 1'b0;
          busy_q          <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] if_grant_cnt_q;
  logic [PERF_CNT_W-1:0] ls_grant_cnt_q;
  logic [PERF_CNT_W-1:0] stall_cnt_q;

  // Free-running wrapping event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_grant_cnt_q <= '0;
      ls_grant_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (grant_if) begin
        if_grant_cnt_q <= if_grant_cnt_q + PERF_CNT_W'(1);
      end
      if (grant_ls) begin
        ls_grant_cnt_q <= ls_grant_cnt_q + PERF_CNT_W'(1);
      end
      if ((state_q == ISSUE) && !mem_req_ready) begin
        stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
      end
    end
  end

  assign if_grant_cnt = if_grant_cnt_q;
  assign ls_grant_cnt = ls_grant_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

  assign if_req_ready  = grant_if;
  assign ls_req_ready  = grant_ls;
  assign if_rsp_valid  = if_rsp_valid_q;
  assign if_rsp_data   = if_rsp_data_q;
  assign ls_rsp_valid  = ls_rsp_valid_q;
  assign ls_rsp_data   = ls_rsp_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign busy          = busy_q;
  assign protocol_err  = protocol_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a request-level arbitration and memory model.
// Define ARB_PERF_CNT_EN to also check the performance counters.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid, ls_req_ready, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic [3:0]  ls_wstrb;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        busy, protocol_err;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_grant_cnt, ls_grant_cnt, stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int starve_m;
  logic [31:0] mem_m [logic [31:0]];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_we         (ls_we),
    .ls_addr       (ls_addr),
    .ls_wdata      (ls_wdata),
    .ls_wstrb      (ls_wstrb),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rsp_data   (ls_rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
`ifdef ARB_PERF_CNT_EN
    .if_grant_cnt  (if_grant_cnt),
    .ls_grant_cnt  (ls_grant_cnt),
    .stall_cnt     (stall_cnt),
`endif
    .busy          (busy),
    .protocol_err  (protocol_err)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_req_valid  = 1'b0; if_addr  = '0;
    ls_req_valid  = 1'b0; ls_we    = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Memory contents seen by the model; untouched words read back as a pattern.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, mem_req_valid, mem_we, if_rsp_valid, ls_rsp_valid, protocol_err, if_req_ready, ls_req_ready} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=00000000",
        {busy, mem_req_valid, mem_we, if_rsp_valid, ls_rsp_valid, protocol_err, if_req_ready, ls_req_ready});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, mem_wstrb, if_rsp_data, ls_rsp_data} !== '0) begin
      n_fail++; $display("FAIL reset_data got addr=%h wdata=%h wstrb=%h ifd=%h lsd=%h exp all 0",
        mem_addr, mem_wdata, mem_wstrb, if_rsp_data, ls_rsp_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_if_read();
    do_reset();
    if_req_valid = 1'b1; if_addr = 32'h100;
    #1;
    n_checks++;
    if ({if_req_ready, ls_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL if_read_ready got=%b exp=10", {if_req_ready, ls_req_ready});
    end
    tick();
    if_req_valid = 1'b0;
    n_checks++;
    if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 1'b0, 32'h100, 32'h0, 4'h0}) begin
      n_fail++; $display("FAIL if_read_req got v=%b we=%b a=%h wd=%h s=%h exp v=1 we=0 a=100 wd=0 s=0",
        mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    n_checks++;
    if ({mem_req_valid, busy, if_rsp_valid} !== 3'b010) begin
      n_fail++; $display("FAIL if_read_wait got=%b exp=010", {mem_req_valid, busy, if_rsp_valid});
    end
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    n_checks++;
    if ({if_rsp_valid, ls_rsp_valid, busy, if_rsp_data} !== {3'b100, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL if_read_rsp got v=%b lsv=%b busy=%b d=%h exp 1 0 0 deadbeef",
        if_rsp_valid, ls_rsp_valid, busy, if_rsp_data);
    end
    tick();
    n_checks++;
    if ({if_rsp_valid, if_rsp_data} !== {1'b0, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL if_read_hold got v=%b d=%h exp 0 deadbeef", if_rsp_valid, if_rsp_data);
    end
  endtask

  task automatic test_priority();
    do_reset();
    if_req_valid = 1'b1; if_addr = 32'h300;
    ls_req_valid = 1'b1; ls_addr = 32'h400; ls_we = 1'b0;
    #1;
    n_checks++;
    if ({if_req_ready, ls_req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL prio_ready got=%b exp=01", {if_req_ready, ls_req_ready});
    end
    tick();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    n_checks++;
    if ({mem_req_valid, mem_addr} !== {1'b1, 32'h400}) begin
      n_fail++; $display("FAIL prio_addr got v=%b a=%h exp 1 400", mem_req_valid, mem_addr);
    end
    n_checks++;
    if ({if_req_ready, ls_req_ready} !== 2'b00) begin
      n_fail++; $display("FAIL busy_ready got=%b exp=00", {if_req_ready, ls_req_ready});
    end
  endtask

  task automatic test_starvation();
    do_reset();
    if_req_valid = 1'b1; if_addr = 32'h500;
    ls_req_valid = 1'b1; ls_addr = 32'h600; ls_we = 1'b0;
    for (int k = 0; k <= int'(MAX_WAIT) + 1; k++) begin
      #1;
      n_checks++;
      if (k == int'(MAX_WAIT)) begin
        if ({if_req_ready, ls_req_ready} !== 2'b10) begin
          n_fail++; $display("FAIL starve_arb%0d got=%b exp=10", k, {if_req_ready, ls_req_ready});
        end
      end else if ({if_req_ready, ls_req_ready} !== 2'b01) begin
        n_fail++; $display("FAIL starve_arb%0d got=%b exp=01", k, {if_req_ready, ls_req_ready});
      end
      if (k == int'(MAX_WAIT) + 1) break;
      tick();
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'(k);
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      n_checks++;
      if ({if_rsp_valid, ls_rsp_valid} !== ((k == int'(MAX_WAIT)) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL starve_rsp%0d got=%b", k, {if_rsp_valid, ls_rsp_valid});
      end
`ifdef ARB_PERF_CNT_EN
      if (k == int'(MAX_WAIT)) begin
        n_checks++;
        if ({ls_grant_cnt, if_grant_cnt} !== {32'd4, 32'd1}) begin
          n_fail++; $display("FAIL perf_grants got ls=%0d if=%0d exp ls=4 if=1", ls_grant_cnt, if_grant_cnt);
        end
      end
`endif
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
  endtask

  task automatic test_write_stall();
    do_reset();
    ls_req_valid = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h1234_5678; ls_wstrb = 4'b0011;
    #1;
    n_checks++;
    if (ls_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_ready got=%b exp=1", ls_req_ready);
    end
    tick();
    ls_req_valid = 1'b0; ls_wdata = 32'hFFFF_FFFF; ls_addr = 32'h0;
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'b0011}) begin
        n_fail++; $display("FAIL wr_stable%0d got v=%b we=%b a=%h wd=%h s=%b", s,
          mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb);
      end
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_AAAA;
    tick();
    mem_rsp_valid = 1'b0;
    n_checks++;
    if ({ls_rsp_valid, if_rsp_valid, ls_rsp_data} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL wr_ack got v=%b ifv=%b d=%h exp 1 0 0", ls_rsp_valid, if_rsp_valid, ls_rsp_data);
    end
`ifdef ARB_PERF_CNT_EN
    n_checks++;
    if (stall_cnt !== 32'd3) begin
      n_fail++; $display("FAIL perf_stall got=%0d exp=3", stall_cnt);
    end
`endif
    tick();
    n_checks++;
    if (ls_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_pulse got=%b exp=0", ls_rsp_valid);
    end
  endtask

  task automatic test_zero_latency();
    do_reset();
    if_req_valid = 1'b1; if_addr = 32'h40;
    tick();
    if_req_valid = 1'b0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    n_checks++;
    if ({if_rsp_valid, busy, mem_req_valid, protocol_err, if_rsp_data} !== {4'b1000, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL zl_rsp got v=%b busy=%b mv=%b err=%b d=%h exp 1 0 0 0 cafef00d",
        if_rsp_valid, busy, mem_req_valid, protocol_err, if_rsp_data);
    end
    ls_req_valid = 1'b1; ls_we = 1'b0;
    #1;
    n_checks++;
    if (ls_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL zl_regrant got=%b exp=1", ls_req_ready);
    end
    tick();
    ls_req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 32'h80;
    tick();
    ls_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    n_checks++;
    if ({busy, protocol_err} !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_pre got=%b exp=10", {busy, protocol_err});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, mem_req_valid} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_abort got=%b exp=00", {busy, mem_req_valid});
    end
    #2 rst = 1'b0;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BAD_0BAD;
    tick();
    mem_rsp_valid = 1'b0;
    n_checks++;
    if ({ls_rsp_valid, if_rsp_valid, busy, protocol_err} !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_err got=%b exp=0001", {ls_rsp_valid, if_rsp_valid, busy, protocol_err});
    end
    tick();
    n_checks++;
    if (protocol_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky got=%b exp=1", protocol_err);
    end
  endtask

  task automatic test_random();
    int g;
    logic ifv, lsv, zl, we_e;
    logic [31:0] ia, la, lw, addr_e, wdata_e, exp_data, bus_data, w;
    logic [3:0] ls_s, strb_e;
    do_reset();
    starve_m = 0;
    for (int t = 0; t < 120; t++) begin
      ifv = ($urandom_range(0, 3) != 0);
      lsv = ($urandom_range(0, 3) != 0);
      ia = 32'($urandom_range(0, 7)) * 32'd4;
      la = 32'($urandom_range(0, 7)) * 32'd4;
      lw = $urandom;
      ls_s = 4'($urandom);
      if_req_valid = ifv; if_addr = ia;
      ls_req_valid = lsv; ls_addr = la; ls_wdata = lw; ls_wstrb = ls_s; ls_we = 1'($urandom);
      #1;
      // 0 = no grant, 1 = IF, 2 = LS.
      g = 0;
      if (ifv && starve_m == int'(MAX_WAIT)) g = 1;
      else if (lsv) g = 2;
      else if (ifv) g = 1;
      n_checks++;
      if ({if_req_ready, ls_req_ready} !== {g == 1, g == 2}) begin
        n_fail++; $display("FAIL rnd%0d_grant got=%b exp=%b starve=%0d", t,
          {if_req_ready, ls_req_ready}, {g == 1, g == 2}, starve_m);
      end
      if (g == 2 && ifv) starve_m = (starve_m < int'(MAX_WAIT)) ? starve_m + 1 : int'(MAX_WAIT);
      if (g == 1) starve_m = 0;
      if (g == 0) begin
        tick();
        continue;
      end
      if (g == 2) begin
        we_e = ls_we; addr_e = la; wdata_e = lw; strb_e = ls_s;
      end else begin
        we_e = 1'b0; addr_e = ia; wdata_e = '0; strb_e = '0;
      end
      tick();
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      for (int s = 0; s <= int'($urandom_range(0, 2)); s++) begin
        if (s != 0) tick();
        n_checks++;
        if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, we_e, addr_e, wdata_e, strb_e}) begin
          n_fail++; $display("FAIL rnd%0d_req got v=%b we=%b a=%h wd=%h s=%b exp 1 %b %h %h %b", t,
            mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, we_e, addr_e, wdata_e, strb_e);
        end
      end
      if (we_e) begin
        w = mem_rd(addr_e);
        for (int b = 0; b < 4; b++) if (strb_e[b]) w[8*b +: 8] = wdata_e[8*b +: 8];
        mem_m[addr_e] = w;
        exp_data = '0;
        bus_data = $urandom;
      end else begin
        exp_data = mem_rd(addr_e);
        bus_data = exp_data;
      end
      zl = 1'($urandom);
      mem_req_ready = 1'b1;
      if (zl) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = bus_data;
      end
      tick();
      mem_req_ready = 1'b0;
      if (!zl) begin
        for (int l = 0; l < int'($urandom_range(0, 2)); l++) tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = bus_data;
        tick();
      end
      mem_rsp_valid = 1'b0;
      n_checks++;
      if ({if_rsp_valid, ls_rsp_valid, busy} !== {g == 1, g == 2, 1'b0} ||
          ((g == 1) ? if_rsp_data : ls_rsp_data) !== exp_data) begin
        n_fail++; $display("FAIL rnd%0d_rsp got ifv=%b lsv=%b busy=%b ifd=%h lsd=%h exp owner=%0d d=%h", t,
          if_rsp_valid, ls_rsp_valid, busy, if_rsp_data, ls_rsp_data, g, exp_data);
      end
    end
    n_checks++;
    if (protocol_err !== 1'b0) begin
      n_fail++; $display("FAIL rnd_err got=%b exp=0", protocol_err);
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_priority();
    test_starvation();
    test_write_stall();
    test_zero_latency();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
